dff_reg_arbiter: RTL and testbench
==================================

Name: dff_reg_arbiter

Overview:
- Round-robin scheduler that shares one WIDTH-bit D-flip-flop register (Q <= D on CLK rising edge) among N requesters.
- Grants ownership to one requester at a time. While granted, that requester's data slice is loaded into the register every cycle.
- Each tenure is capped at MAX_HOLD loads for fairness.
- Sits between requester logic and the shared storage register; the register itself is internal to this block.

Parameters:
- N, 4, number of requesters (2..16)
- IDXW, 2, width of OWNER; must equal ceil(log2(N))
- WIDTH, 8, data width of the shared register
- MAX_HOLD, 4, maximum consecutive loads per tenure (>=1)
- CNTW, 3, tenure counter width; must hold MAX_HOLD

Ports:
- CLK  input  1  clock, rising-edge active
- CLR_N  input  1  reset, asynchronous, active-low
- REQ  input  N  per-requester request, level-sensitive
- DIN  input  N*WIDTH  requester data; slice k = DIN[k*WIDTH +: WIDTH]
- GNT  output  N  one-hot grant, all-zero when no owner
- Q  output  WIDTH  shared register contents
- OWNER  output  IDXW  index of current/last granted requester
- BUSY  output  1  high while a grant is active

Behaviour:
- One clock (CLK); reset is asynchronous and active-low (CLR_N). All flops clear immediately on CLR_N=0, independent of CLK.
- Reset values:
  - GNT=0, Q=0, OWNER=0, BUSY=0
  - state=IDLE, tenure counter=0
  - priority pointer=0 (requester 0 highest)
- States: IDLE, BUSY. BUSY output = (state==BUSY); GNT is nonzero exactly when state==BUSY.
- IDLE, at a rising edge with REQ!=0:
  - Winner w = first k with REQ[k]=1, scanning circularly from pointer upward.
  - GNT<=onehot(w), OWNER<=w, state<=BUSY, counter<=0, pointer<=(w+1) mod N.
  - Q is not loaded on this edge.
- IDLE with REQ==0: hold everything; Q retains value.
- BUSY with owner k, at a rising edge:
  - REQ[k]=1:
    - Q<=DIN slice k; counter<=counter+1.
    - If counter+1==MAX_HOLD: state<=IDLE, GNT<=0 (forced release after exactly MAX_HOLD loads).
  - REQ[k]=0: no load; state<=IDLE, GNT<=0.
  - REQ and DIN of non-owners are ignored entirely.
- Latency:
  - REQ asserted in IDLE -> GNT visible after 1 edge.
  - First load on the following edge; Q shows the data 2 edges after REQ is sampled.
- Every tenure ends with at least one IDLE cycle (GNT=0) before the next grant, including when the same or other requests are still pending.
- The pointer advances at grant time, so a forcibly released requester is lowest priority at the next arbitration. N constant requesters are served in order 0,1,...,N-1,0.
- OWNER holds the last granted index in IDLE. It is meaningful only while BUSY=1.
- Q holds its value across IDLE, grant edges and release; it changes only on owner loads or reset.
- Counter arithmetic is unsigned. The counter never exceeds MAX_HOLD and never wraps.
- Reset asserted mid-tenure: tenure aborts immediately; outputs return to reset values. After CLR_N rises, arbitration restarts from pointer 0.
- No combinational path from REQ or DIN to any output; all outputs are registered.

Test Plan (N=4, WIDTH=8, MAX_HOLD=4 unless stated):
- Reset: run traffic, pull CLR_N low between edges -> GNT=4'b0000, Q=8'h00, BUSY=0, OWNER=0 immediately without waiting for a CLK edge; first grant after release goes to lowest-index requester at or after 0.
- Single requester: REQ=4'b0010, slice1=8'hA5 held -> GNT=4'b0010 after 1 edge; Q=8'hA5 after next edge; GNT drops after 4 loads for exactly 1 cycle, then regrants to 1.
- Full contention: REQ=4'b1111 constant, slice k=8'h10+k -> owners 0,1,2,3,0 in order. Each tenure is 4 loads with a 1-cycle IDLE gap; Q cycles 8'h10,8'h11,8'h12,8'h13.
- Early release: REQ=4'b0100, slice2=8'h3C, drop REQ[2] after 2 loads -> GNT=0 on next edge; Q stays 8'h3C; counter restarts at 0 on next grant.
- Isolation: owner 0 granted with slice0=8'h55 while slices 1-3 toggle every cycle -> Q only ever equals 8'h55.
- MAX_HOLD=1 override with REQ=4'b1001 -> alternating grants 0,3,0,3. Each tenure is exactly one load followed by one IDLE cycle.

Source files
------------

// File: rtl/dff_reg_arbiter.sv
// -----------------------------------------------------------------------------
// dff_reg_arbiter
//   Round-robin scheduler that shares one WIDTH-bit storage register among N
//   requesters. One requester owns the register at a time. While it owns the
//   register, its data slice is loaded on every cycle that it keeps requesting.
//   A tenure ends after MAX_HOLD loads or when the owner drops its request.
//   At least one idle cycle always separates two tenures.
//
// Ports
//   CLK    in   1        clock, rising edge
//   CLR_N  in   1        asynchronous active-low clear
//   REQ    in   N        level-sensitive requests
//   DIN    in   N*WIDTH  requester data, slice k = DIN[k*WIDTH +: WIDTH]
//   GNT    out  N        one-hot grant, zero when there is no owner
//   Q      out  WIDTH    shared register contents
//   OWNER  out  IDXW     current or last granted index
//   BUSY   out  1        high while a grant is active
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | no owner; arbitrate among REQ on the next edge, Q holds
// S_BUSY | OWNER holds the register; load its slice while it requests
// -----------------------------------------------------------------------------
module dff_reg_arbiter #(
  parameter int N        = 4,
  parameter int IDXW     = 2,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4,
  parameter int CNTW     = 3
) (
  input  logic               CLK,
  input  logic               CLR_N,
  input  logic [N-1:0]       REQ,
  input  logic [N*WIDTH-1:0] DIN,
  output logic [N-1:0]       GNT,
  output logic [WIDTH-1:0]   Q,
  output logic [IDXW-1:0]    OWNER,
  output logic               BUSY
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [N-1:0]    ONE_HOT_0 = N'(1);
  localparam logic [CNTW-1:0] HOLD_LIM  = CNTW'(MAX_HOLD);

  logic [0:0]       state_q;
  logic [CNTW-1:0]  cnt_q;
  logic [IDXW-1:0]  ptr_q;

  logic             win_found;
  logic [IDXW-1:0]  win_idx;
  logic [IDXW-1:0]  scan_idx;
  logic [IDXW-1:0]  ptr_next;
  logic [CNTW-1:0]  cnt_inc;
  logic [WIDTH-1:0] owner_slice;
  logic             owner_req;

  // Circular scan starting at the pointer; the first requester seen wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < N; i++) begin
      scan_idx = IDXW'((int'(ptr_q) + i) % N);
      if (!win_found && REQ[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Pointer moves past the winner at grant time, so a requester that was
  // forcibly released becomes lowest priority at the next arbitration.
  assign ptr_next    = IDXW'((int'(win_idx) + 1) % N);
  assign cnt_inc     = cnt_q + CNTW'(1);
  assign owner_req   = REQ[OWNER];
  assign owner_slice = DIN[OWNER*WIDTH +: WIDTH];

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      GNT     <= '0;
      OWNER   <= '0;
      Q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            state_q <= S_BUSY;
            GNT     <= ONE_HOT_0 << win_idx;
            OWNER   <= win_idx;
            cnt_q   <= '0;
            ptr_q   <= ptr_next;
          end
        end
        S_BUSY: begin
          if (owner_req) begin
            Q     <= owner_slice;
            cnt_q <= cnt_inc;
            if (cnt_inc == HOLD_LIM) begin
              state_q <= S_IDLE;
              GNT     <= '0;
            end
          end else begin
            state_q <= S_IDLE;
            GNT     <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          GNT     <= '0;
        end
      endcase
    end
  end

  assign BUSY = (state_q == S_BUSY);

endmodule

// File: tb/tb_dff_reg_arbiter.sv
module tb_dff_reg_arbiter;

  logic        CLK;
  logic        CLR_N;
  logic [3:0]  REQ;
  logic [31:0] DIN;
  logic [3:0]  GNT;
  logic [7:0]  Q;
  logic [1:0]  OWNER;
  logic        BUSY;

  logic [3:0]  REQ1;
  logic [31:0] DIN1;
  logic [3:0]  GNT1;
  logic [7:0]  Q1;
  logic [1:0]  OWNER1;
  logic        BUSY1;

  int n_checks;
  int n_fail;

  dff_reg_arbiter #(.N(4), .IDXW(2), .WIDTH(8), .MAX_HOLD(4), .CNTW(3)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .REQ(REQ), .DIN(DIN),
    .GNT(GNT), .Q(Q), .OWNER(OWNER), .BUSY(BUSY)
  );

  dff_reg_arbiter #(.N(4), .IDXW(2), .WIDTH(8), .MAX_HOLD(1), .CNTW(3)) dut1 (
    .CLK(CLK), .CLR_N(CLR_N), .REQ(REQ1), .DIN(DIN1),
    .GNT(GNT1), .Q(Q1), .OWNER(OWNER1), .BUSY(BUSY1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    CLR_N = 1'b0;
    REQ = '0; REQ1 = '0; DIN = '0; DIN1 = '0;
    tick();
    tick();
    #2 CLR_N = 1'b1;
  endtask

  task automatic test_reset();
    REQ = '0; REQ1 = '0; DIN = '0; DIN1 = '0;
    CLR_N = 1'b1;
    #1 CLR_N = 1'b0;
    #1;
    n_checks++;
    if ({GNT, Q, OWNER, BUSY} !== {4'b0000, 8'h00, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: gnt=%b q=%h owner=%0d busy=%b, want 0000/00/0/0",
               GNT, Q, OWNER, BUSY);
    end
    n_checks++;
    if ({GNT1, Q1, BUSY1} !== {4'b0000, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async_dut1: gnt=%b q=%h busy=%b, want 0000/00/0", GNT1, Q1, BUSY1);
    end
    tick();
    #2 CLR_N = 1'b1;
    tick();
    n_checks++;
    if ({GNT, BUSY} !== {4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_idle_no_req: gnt=%b busy=%b, want 0000/0", GNT, BUSY);
    end
  endtask

  task automatic test_single();
    do_reset();
    DIN = 32'h0000_A500;
    REQ = 4'b0010;
    tick();
    n_checks++;
    if ({GNT, OWNER, BUSY, Q} !== {4'b0010, 2'd1, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL single_grant: gnt=%b owner=%0d busy=%b q=%h, want 0010/1/1/00",
               GNT, OWNER, BUSY, Q);
    end
    for (int l = 1; l <= 4; l++) begin
      tick();
      n_checks++;
      if (Q !== 8'hA5) begin
        n_fail++;
        $display("FAIL single_load%0d: q=%h, want a5", l, Q);
      end
      n_checks++;
      if (GNT !== ((l < 4) ? 4'b0010 : 4'b0000)) begin
        n_fail++;
        $display("FAIL single_gnt_after_load%0d: gnt=%b, want %b", l, GNT,
                 (l < 4) ? 4'b0010 : 4'b0000);
      end
    end
    tick();
    n_checks++;
    if ({GNT, OWNER, Q} !== {4'b0010, 2'd1, 8'hA5}) begin
      n_fail++;
      $display("FAIL single_regrant: gnt=%b owner=%0d q=%h, want 0010/1/a5", GNT, OWNER, Q);
    end
    REQ = 4'b0000;
    tick();
  endtask

  task automatic test_contention();
    logic [3:0] exp_g;
    logic [7:0] exp_q;
    do_reset();
    DIN = 32'h1312_1110;
    REQ = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_g = 4'b0001 << (t % 4);
      exp_q = 8'h10 + 8'(t % 4);
      tick();
      n_checks++;
      if ({GNT, OWNER, BUSY} !== {exp_g, 2'(t % 4), 1'b1}) begin
        n_fail++;
        $display("FAIL contention_grant%0d: gnt=%b owner=%0d busy=%b, want %b/%0d/1",
                 t, GNT, OWNER, BUSY, exp_g, t % 4);
      end
      for (int l = 1; l <= 4; l++) begin
        tick();
        n_checks++;
        if (Q !== exp_q) begin
          n_fail++;
          $display("FAIL contention_q t%0d l%0d: q=%h, want %h", t, l, Q, exp_q);
        end
        n_checks++;
        if ({GNT, BUSY} !== ((l < 4) ? {exp_g, 1'b1} : {4'b0000, 1'b0})) begin
          n_fail++;
          $display("FAIL contention_hold t%0d l%0d: gnt=%b busy=%b", t, l, GNT, BUSY);
        end
      end
    end
    REQ = '0;
    tick();
  endtask

  task automatic test_early_release();
    do_reset();
    DIN = 32'h003C_0000;
    REQ = 4'b0100;
    tick();
    tick();
    tick();
    n_checks++;
    if ({GNT, Q} !== {4'b0100, 8'h3C}) begin
      n_fail++;
      $display("FAIL early_two_loads: gnt=%b q=%h, want 0100/3c", GNT, Q);
    end
    REQ = 4'b0000;
    DIN = 32'h00FF_0000;
    tick();
    n_checks++;
    if ({GNT, BUSY, Q} !== {4'b0000, 1'b0, 8'h3C}) begin
      n_fail++;
      $display("FAIL early_release: gnt=%b busy=%b q=%h, want 0000/0/3c", GNT, BUSY, Q);
    end
    tick();
    n_checks++;
    if (Q !== 8'h3C) begin
      n_fail++;
      $display("FAIL early_q_hold: q=%h, want 3c", Q);
    end
    DIN = 32'h003D_0000;
    REQ = 4'b0100;
    tick();
    n_checks++;
    if ({GNT, OWNER, Q} !== {4'b0100, 2'd2, 8'h3C}) begin
      n_fail++;
      $display("FAIL early_regrant: gnt=%b owner=%0d q=%h, want 0100/2/3c", GNT, OWNER, Q);
    end
    // A fresh tenure must again last four loads.
    for (int l = 1; l <= 4; l++) begin
      tick();
      n_checks++;
      if ({GNT, Q} !== ((l < 4) ? {4'b0100, 8'h3D} : {4'b0000, 8'h3D})) begin
        n_fail++;
        $display("FAIL early_new_tenure l%0d: gnt=%b q=%h", l, GNT, Q);
      end
    end
    REQ = '0;
    tick();
  endtask

  task automatic test_isolation();
    do_reset();
    DIN = 32'h0000_0055;
    REQ = 4'b0001;
    tick();
    n_checks++;
    if ({GNT, Q} !== {4'b0001, 8'h00}) begin
      n_fail++;
      $display("FAIL iso_grant: gnt=%b q=%h, want 0001/00", GNT, Q);
    end
    for (int l = 1; l <= 4; l++) begin
      DIN[31:8] = (l % 2 == 1) ? 24'hAAAA_AA : 24'h5A_C3F0;
      REQ[3:1]  = (l % 2 == 1) ? 3'b111 : 3'b010;
      tick();
      n_checks++;
      if (Q !== 8'h55) begin
        n_fail++;
        $display("FAIL iso_q l%0d: q=%h, want 55", l, Q);
      end
    end
    REQ = '0;
    tick();
    n_checks++;
    if ({GNT, Q} !== {4'b0000, 8'h55}) begin
      n_fail++;
      $display("FAIL iso_after: gnt=%b q=%h, want 0000/55", GNT, Q);
    end
  endtask

  task automatic test_max_hold1();
    logic [1:0] exp_o;
    logic [7:0] exp_q;
    do_reset();
    DIN1 = 32'h7300_0070;
    REQ1 = 4'b1001;
    for (int t = 0; t < 4; t++) begin
      exp_o = (t % 2 == 0) ? 2'd0 : 2'd3;
      exp_q = (t % 2 == 0) ? 8'h70 : 8'h73;
      tick();
      n_checks++;
      if ({GNT1, OWNER1, BUSY1} !== {4'b0001 << exp_o, exp_o, 1'b1}) begin
        n_fail++;
        $display("FAIL mh1_grant%0d: gnt=%b owner=%0d busy=%b, want owner %0d",
                 t, GNT1, OWNER1, BUSY1, exp_o);
      end
      tick();
      n_checks++;
      if ({GNT1, BUSY1, Q1} !== {4'b0000, 1'b0, exp_q}) begin
        n_fail++;
        $display("FAIL mh1_load%0d: gnt=%b busy=%b q=%h, want 0000/0/%h",
                 t, GNT1, BUSY1, Q1, exp_q);
      end
    end
    REQ1 = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    DIN = 32'h1312_1110;
    REQ = 4'b0010;
    tick();
    tick();
    n_checks++;
    if ({GNT, Q} !== {4'b0010, 8'h11}) begin
      n_fail++;
      $display("FAIL mid_pre: gnt=%b q=%h, want 0010/11", GNT, Q);
    end
    #2 CLR_N = 1'b0;
    #1;
    n_checks++;
    if ({GNT, Q, OWNER, BUSY} !== {4'b0000, 8'h00, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset_async: gnt=%b q=%h owner=%0d busy=%b, want 0000/00/0/0",
               GNT, Q, OWNER, BUSY);
    end
    REQ = 4'b1111;
    #1 CLR_N = 1'b1;
    tick();
    n_checks++;
    if ({GNT, OWNER, Q} !== {4'b0001, 2'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL mid_restart_ptr: gnt=%b owner=%0d q=%h, want 0001/0/00", GNT, OWNER, Q);
    end
    REQ = '0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_contention();
    test_early_release();
    test_isolation();
    test_max_hold1();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
